alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
Integer execute stage sitting directly downstream of the reservation station. It consumes one issued RV32I operation per cycle (op enum, V1, V2, imm, inst_pos, rob_id) and computes the result, plus branch/jump resolution. It holds the result in a single output register until the CDB arbiter grants the broadcast slot. It back-pressures the RS through busy_to_rs while a result is waiting and not granted.

Parameters:
DATA_W, 32, data/address width
ROB_ID_W, 4, ROB tag width
OP_W, 6, op enum width (encoding in shared constants)

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  reset; asynchronous, active-low
rdy_in  in  1  global enable; low freezes all state
op_enum_in  in  OP_W  issued op; OP_ENUM_RESET means no issue this cycle
V1_in  in  DATA_W  source operand 1
V2_in  in  DATA_W  source operand 2
imm_in  in  DATA_W  sign-extended immediate
inst_pos_in  in  DATA_W  PC of issued instruction
rob_id_in  in  ROB_ID_W  ROB tag of issued instruction
busy_to_rs  out  1  RS must not issue while high
cdb_grant_in  in  1  arbiter grants CDB slot this cycle
cdb_valid  out  1  result valid on CDB
cdb_rob_id  out  ROB_ID_W  tag of result
cdb_result  out  DATA_W  rd value
cdb_jump_flag  out  1  branch taken / jump
cdb_target_pc  out  DATA_W  resolved next PC
rollback_in  in  1  ROB misprediction flush

Behaviour:
- Reset (rst_in low, async): cdb_valid=0; cdb_rob_id=ROB_ID_RESET; cdb_result, cdb_target_pc=0; cdb_jump_flag=0. busy_to_rs evaluates to 0.
- Issue is accepted at a posedge when all hold: rdy_in=1, rollback_in=0, op_enum_in != OP_ENUM_RESET, busy_to_rs=0.
- busy_to_rs = cdb_valid && !cdb_grant_in (combinational). Back-to-back issue is allowed when the held result is granted in the same cycle.
- Latency: operation accepted at edge N drives cdb_valid=1 from N until the edge at which it is granted. Minimum one cycle.
- Output register update at posedge with rdy_in=1, in priority order:
  1. rollback_in=1: cdb_valid<=0 and the input is discarded.
  2. Issue accepted: load the computed fields and set cdb_valid<=1. This covers a simultaneous grant of the old result.
  3. cdb_valid && cdb_grant_in: cdb_valid<=0.
  4. Otherwise: hold all outputs.
- rdy_in=0: all registers hold and no issue is accepted. busy_to_rs still follows its equation.
- Arithmetic is modulo 2^DATA_W. Shift amount is the low 5 bits of V2, or of imm for the immediate forms. SRA/SRAI are arithmetic. SLT/SLTI/BLT/BGE are signed; the U variants are unsigned.
- Per-class results:
  - ALU and ALU-imm ops: result = V1 op V2 (or V1 op imm); jump_flag=0; target=inst_pos+4.
  - LUI: result=imm.
  - AUIPC: result=inst_pos+imm.
  - JAL: result=inst_pos+4; target=inst_pos+imm; jump_flag=1.
  - JALR: result=inst_pos+4; target=(V1+imm) & ~1; jump_flag=1.
  - Branches: result=0; jump_flag=condition(V1,V2); target = taken ? inst_pos+imm : inst_pos+4.
  - Unknown nonzero op: result=0, jump_flag=0, target=inst_pos+4, still broadcast.
- Rollback while a result is held: the result is dropped and never broadcast.
- Asserting cdb_grant_in while cdb_valid=0 has no effect.

Decomposition:
- Shared constants package (existing constants header): OP_ENUM_* encodings, OP_ENUM_RESET, ROB_ID_RESET, DATA_TYPE/ROB_ID_TYPE/OP_ENUM_TYPE width macros, DATA_RESET.
- Sub-module alu_compute: purely combinational. Takes op, V1, V2, imm, inst_pos and returns result, jump_flag, target.
- alu_exec_unit contains only the output register, handshake and flush logic.

Test Plan:
- ADD V1=0xFFFFFFFF, V2=2, rob 3, grant held high -> next cycle cdb_valid=1, rob 3, result=0x00000001, jump_flag=0; cdb_valid=0 the following cycle with no new issue.
- SRA V1=0x80000000, V2=0x24 (shamt 4); then SLTU V1=1, V2=0xFFFFFFFF -> results 0xF8000000 then 1.
- BNE V1=5, V2=6, inst_pos=0x100, imm=-8 -> jump_flag=1, target=0xF8. JALR V1=0x203, imm=0, inst_pos=0x40 -> target=0x202, result=0x44.
- Grant low for 3 cycles after an issue -> cdb_valid and fields stable and busy_to_rs=1 for 3 cycles. Issue attempt during the stall is not accepted. Grant=1 with a new issue in the same cycle -> new result loaded, busy_to_rs=0 that cycle.
- Held result plus rollback_in=1 together with an issued op -> cdb_valid=0 next cycle, no broadcast of either.
- rst_in pulsed low mid-hold, asynchronously between edges -> cdb_valid drops to 0 immediately. rdy_in=0 during an issue -> no state change.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// Shared constants for the integer execute stage.
// Holds the op encodings issued by the reservation station, the reset values
// of the result bus fields, and the default widths of the data, ROB-tag and
// op-enum types.
package alu_exec_unit_pkg;

  localparam int DATA_TYPE_W    = 32;
  localparam int ROB_ID_TYPE_W  = 4;
  localparam int OP_ENUM_TYPE_W = 6;

  localparam logic [DATA_TYPE_W-1:0]   DATA_RESET   = '0;
  localparam logic [ROB_ID_TYPE_W-1:0] ROB_ID_RESET = '0;

  typedef enum logic [OP_ENUM_TYPE_W-1:0] {
    OP_ENUM_RESET = 6'd0,
    OP_ENUM_LUI   = 6'd1,
    OP_ENUM_AUIPC = 6'd2,
    OP_ENUM_JAL   = 6'd3,
    OP_ENUM_JALR  = 6'd4,
    OP_ENUM_BEQ   = 6'd5,
    OP_ENUM_BNE   = 6'd6,
    OP_ENUM_BLT   = 6'd7,
    OP_ENUM_BGE   = 6'd8,
    OP_ENUM_BLTU  = 6'd9,
    OP_ENUM_BGEU  = 6'd10,
    OP_ENUM_ADDI  = 6'd11,
    OP_ENUM_SLTI  = 6'd12,
    OP_ENUM_SLTIU = 6'd13,
    OP_ENUM_XORI  = 6'd14,
    OP_ENUM_ORI   = 6'd15,
    OP_ENUM_ANDI  = 6'd16,
    OP_ENUM_SLLI  = 6'd17,
    OP_ENUM_SRLI  = 6'd18,
    OP_ENUM_SRAI  = 6'd19,
    OP_ENUM_ADD   = 6'd20,
    OP_ENUM_SUB   = 6'd21,
    OP_ENUM_SLL   = 6'd22,
    OP_ENUM_SLT   = 6'd23,
    OP_ENUM_SLTU  = 6'd24,
    OP_ENUM_XOR   = 6'd25,
    OP_ENUM_SRL   = 6'd26,
    OP_ENUM_SRA   = 6'd27,
    OP_ENUM_OR    = 6'd28,
    OP_ENUM_AND   = 6'd29
  } op_enum_e;

  // Register-immediate ALU forms take their second operand from imm.
  function automatic logic op_uses_imm(op_enum_e op);
    return (op >= OP_ENUM_ADDI) && (op <= OP_ENUM_SRAI);
  endfunction

endpackage

// File: rtl/alu_exec_unit_compute.sv
// Combinational RV32I compute core.
// Ports:
//   op        : issued op encoding
//   v1, v2    : source operands
//   imm       : sign-extended immediate
//   inst_pos  : PC of the instruction
//   result    : rd value
//   jump_flag : branch taken / unconditional jump
//   target    : resolved next PC
module alu_compute
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_W = DATA_TYPE_W,
  parameter int OP_W   = OP_ENUM_TYPE_W
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] v1,
  input  logic [DATA_W-1:0] v2,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] inst_pos,
  output logic [DATA_W-1:0] result,
  output logic              jump_flag,
  output logic [DATA_W-1:0] target
);

  op_enum_e                 op_k;
  logic [DATA_W-1:0]        opb;
  logic signed [DATA_W-1:0] v1_s;
  logic signed [DATA_W-1:0] opb_s;
  logic [4:0]               shamt;
  logic [DATA_W-1:0]        pc_next;
  logic [DATA_W-1:0]        pc_rel;

  assign op_k    = op_enum_e'(op);
  assign opb     = op_uses_imm(op_k) ? imm : v2;
  assign v1_s    = $signed(v1);
  assign opb_s   = $signed(opb);
  assign shamt   = opb[4:0];
  assign pc_next = inst_pos + DATA_W'(4);
  assign pc_rel  = inst_pos + imm;

  function automatic logic branch_taken(op_enum_e o, logic [DATA_W-1:0] a,
                                        logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    a_s = $signed(a);
    b_s = $signed(b);
    case (o)
      OP_ENUM_BEQ:  return a == b;
      OP_ENUM_BNE:  return a != b;
      OP_ENUM_BLT:  return a_s < b_s;
      OP_ENUM_BGE:  return a_s >= b_s;
      OP_ENUM_BLTU: return a < b;
      OP_ENUM_BGEU: return a >= b;
      default:      return 1'b0;
    endcase
  endfunction

  always_comb begin
    result    = '0;
    jump_flag = 1'b0;
    target    = pc_next;
    case (op_k)
      OP_ENUM_LUI:   result = imm;
      OP_ENUM_AUIPC: result = pc_rel;
      OP_ENUM_JAL: begin
        result    = pc_next;
        target    = pc_rel;
        jump_flag = 1'b1;
      end
      OP_ENUM_JALR: begin
        result    = pc_next;
        target    = (v1 + imm) & ~DATA_W'(1);
        jump_flag = 1'b1;
      end
      OP_ENUM_BEQ, OP_ENUM_BNE, OP_ENUM_BLT,
      OP_ENUM_BGE, OP_ENUM_BLTU, OP_ENUM_BGEU: begin
        jump_flag = branch_taken(op_k, v1, v2);
        target    = jump_flag ? pc_rel : pc_next;
      end
      OP_ENUM_ADD, OP_ENUM_ADDI:   result = v1 + opb;
      OP_ENUM_SUB:                 result = v1 - opb;
      OP_ENUM_SLT, OP_ENUM_SLTI:   result = DATA_W'(v1_s < opb_s);
      OP_ENUM_SLTU, OP_ENUM_SLTIU: result = DATA_W'(v1 < opb);
      OP_ENUM_XOR, OP_ENUM_XORI:   result = v1 ^ opb;
      OP_ENUM_OR, OP_ENUM_ORI:     result = v1 | opb;
      OP_ENUM_AND, OP_ENUM_ANDI:   result = v1 & opb;
      OP_ENUM_SLL, OP_ENUM_SLLI:   result = v1 << shamt;
      OP_ENUM_SRL, OP_ENUM_SRLI:   result = v1 >> shamt;
      OP_ENUM_SRA, OP_ENUM_SRAI:   result = v1_s >>> shamt;
      default: begin
        result    = '0;
        jump_flag = 1'b0;
        target    = pc_next;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Integer execute stage: computes an issued RV32I op and holds the result in a
// single output register until the CDB arbiter grants the broadcast slot.
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global enable)
//   op_enum_in/V1_in/V2_in/imm_in/inst_pos_in/rob_id_in : issued operation
//   busy_to_rs    : RS must not issue while high
//   cdb_grant_in  : arbiter grants the CDB slot this cycle
//   cdb_valid/cdb_rob_id/cdb_result/cdb_jump_flag/cdb_target_pc : broadcast
//   rollback_in   : misprediction flush, drops held and incoming results
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_W   = DATA_TYPE_W,
  parameter int ROB_ID_W = ROB_ID_TYPE_W,
  parameter int OP_W     = OP_ENUM_TYPE_W
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic [OP_W-1:0]     op_enum_in,
  input  logic [DATA_W-1:0]   V1_in,
  input  logic [DATA_W-1:0]   V2_in,
  input  logic [DATA_W-1:0]   imm_in,
  input  logic [DATA_W-1:0]   inst_pos_in,
  input  logic [ROB_ID_W-1:0] rob_id_in,
  output logic                busy_to_rs,
  input  logic                cdb_grant_in,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [DATA_W-1:0]   cdb_result,
  output logic                cdb_jump_flag,
  output logic [DATA_W-1:0]   cdb_target_pc,
  input  logic                rollback_in
);

  logic [DATA_W-1:0] calc_result;
  logic [DATA_W-1:0] calc_target;
  logic              calc_jump;
  logic              issue_ok;

  alu_compute #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_compute (
    .op        (op_enum_in),
    .v1        (V1_in),
    .v2        (V2_in),
    .imm       (imm_in),
    .inst_pos  (inst_pos_in),
    .result    (calc_result),
    .jump_flag (calc_jump),
    .target    (calc_target)
  );

  // A held result blocks new issue unless it leaves on the bus this cycle,
  // which lets the RS issue back-to-back behind a granted result.
  assign busy_to_rs = cdb_valid && !cdb_grant_in;

  assign issue_ok = rdy_in && !rollback_in && !busy_to_rs &&
                    (op_enum_in != OP_W'(OP_ENUM_RESET));

  // Output register stage: compute results become the CDB broadcast.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb_valid     <= 1'b0;
      cdb_rob_id    <= ROB_ID_W'(ROB_ID_RESET);
      cdb_result    <= DATA_W'(DATA_RESET);
      cdb_jump_flag <= 1'b0;
      cdb_target_pc <= DATA_W'(DATA_RESET);
    end else if (rdy_in) begin
      if (rollback_in) begin
        cdb_valid <= 1'b0;
      end else if (issue_ok) begin
        cdb_valid     <= 1'b1;
        cdb_rob_id    <= rob_id_in;
        cdb_result    <= calc_result;
        cdb_jump_flag <= calc_jump;
        cdb_target_pc <= calc_target;
      end else if (cdb_valid && cdb_grant_in) begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule
